// File: rtl/raster_tri_scheduler_pkg.sv
// Shared types for the triangle scheduler: setup descriptor layout and FSM states.
// No logic beyond the degenerate-bounding-box test used at issue time.
// Bounds are signed so triangles straddling the origin are not mistaken for empty ones.
package raster_pkg;

    typedef struct packed {
        logic signed [31:0] ymin;
        logic signed [31:0] ymax;
        logic signed [31:0] xmin;
        logic signed [31:0] xmax;
        logic [31:0]        l0_dx;
        logic [31:0]        l0_dy;
        logic [31:0]        l1_dx;
        logic [31:0]        l1_dy;
        logic [31:0]        l2_dx;
        logic [31:0]        l2_dy;
        logic [31:0]        w0_00;
        logic [31:0]        w1_00;
        logic [31:0]        w2_00;
        logic [31:0]        recip_area;
        logic [31:0]        v0_raster_z;
        logic [31:0]        v1_raster_z;
        logic [31:0]        v2_raster_z;
    } tri_setup_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        LAUNCH,
        RUN,
        REPORT
    } sched_state_e;

    function automatic logic is_degenerate(input tri_setup_t t);
        return (t.xmin > t.xmax) || (t.ymin > t.ymax);
    endfunction

endpackage

// File: rtl/raster_tri_scheduler_if.sv
// Bundles the setup stream, fragment-generator control and report signals of the scheduler.
// master = scheduler side, slave = surrounding pipeline (setup, generator, shader).
// No storage; flow control is carried by tri_valid/tri_ready and fg_ready.
interface raster_tri_scheduler_if #(
    parameter int ID_W = 8
);
    logic                   tri_valid;
    logic                   tri_ready;
    raster_pkg::tri_setup_t tri_in;
    logic                   fg_start;
    raster_pkg::tri_setup_t fg_setup;
    logic                   fg_ready;
    logic                   fg_done;
    logic                   fg_frag_val;
    logic                   fg_pop_frag;
    logic                   rpt_valid;
    logic [ID_W-1:0]        rpt_id;
    logic [31:0]            rpt_frag_cnt;
    logic                   busy;
    logic                   err_timeout;

    modport master (
        input  tri_valid, tri_in, fg_ready, fg_done, fg_frag_val, fg_pop_frag,
        output tri_ready, fg_start, fg_setup, rpt_valid, rpt_id, rpt_frag_cnt,
               busy, err_timeout
    );

    modport slave (
        output tri_valid, tri_in, fg_ready, fg_done, fg_frag_val, fg_pop_frag,
        input  tri_ready, fg_start, fg_setup, rpt_valid, rpt_id, rpt_frag_cnt,
               busy, err_timeout
    );
endinterface

// File: rtl/raster_tri_scheduler_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read data.
// Latency: write visible at head one cycle after push.
// Backpressure: caller must not push when full nor pop when empty.
module raster_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;

endmodule

// File: rtl/raster_tri_scheduler.sv
// Queues triangle setups, launches the fragment generator one triangle at a time, reports fragment counts.
// Latency: push into empty FIFO to fg_start is 3 cycles; degenerate triangles report 3 cycles after push.
// Backpressure: tri_ready drops when the FIFO is full; fg_start waits for fg_ready; reports are never stalled.
module raster_tri_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ID_W       = 8,
    parameter int TIMEOUT    = 65536
) (
    input  logic                    clk,
    input  logic                    rst,
    raster_tri_scheduler_if.master  io
);
    import raster_pkg::*;

    localparam int FW   = $bits(tri_setup_t) + ID_W;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_e              state, state_nxt;
    logic [ID_W-1:0]           id_cnt;
    logic [ID_W-1:0]           cur_id;
    tri_setup_t                setup_q;
    logic [31:0]               frag_cnt;
    logic [WD_W-1:0]           wd_cnt;
    logic                      err_q;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic [FW-1:0]             fifo_rd_dat;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [ID_W-1:0]           head_id;
    tri_setup_t                head_setup;

    logic                      start;
    logic                      rpt;
    logic                      wd_expire;
    logic                      frag_fire;

    // Ready is based on occupancy before any same-cycle pop.
    assign fifo_push = io.tri_valid && !fifo_full;
    assign {head_id, head_setup} = fifo_rd_dat;
    assign frag_fire = io.fg_frag_val && io.fg_pop_frag;

    raster_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_dat ({id_cnt, io.tri_in}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        start     = 1'b0;
        rpt       = 1'b0;
        wd_expire = 1'b0;
        case (state)
            IDLE:   if (!fifo_empty) state_nxt = ISSUE;
            ISSUE: begin
                fifo_pop  = 1'b1;
                state_nxt = is_degenerate(head_setup) ? REPORT : LAUNCH;
            end
            LAUNCH: if (io.fg_ready) begin
                start     = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (io.fg_done) begin
                    state_nxt = REPORT;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = REPORT;
                end
            end
            REPORT: begin
                rpt       = 1'b1;
                state_nxt = fifo_empty ? IDLE : ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            id_cnt   <= '0;
            cur_id   <= '0;
            setup_q  <= '0;
            frag_cnt <= '0;
            wd_cnt   <= '0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (fifo_push) id_cnt <= id_cnt + 1'b1;
            if (fifo_pop) begin
                setup_q <= head_setup;
                cur_id  <= head_id;
            end
            // Count saturates; the final pop coinciding with fg_done still lands before REPORT.
            if (state == RUN) begin
                if (frag_fire && (frag_cnt != 32'hFFFF_FFFF)) frag_cnt <= frag_cnt + 32'd1;
            end else if (state == REPORT) begin
                frag_cnt <= '0;
            end
            wd_cnt <= (state == RUN) ? wd_cnt + 1'b1 : '0;
            if (wd_expire) err_q <= 1'b1;
        end
    end

    assign io.tri_ready    = !fifo_full;
    assign io.fg_start     = start;
    assign io.fg_setup     = setup_q;
    assign io.rpt_valid    = rpt;
    assign io.rpt_id       = cur_id;
    assign io.rpt_frag_cnt = frag_cnt;
    assign io.busy         = (fifo_count != '0) || (state != IDLE);
    assign io.err_timeout  = err_q;

endmodule

// File: tb/tb_raster_tri_scheduler.sv
// Bench for raster_tri_scheduler: table-driven directed triangles, corner-case sequences and a random run.
// A behavioural generator/consumer drives the fragment side; reports are scoreboarded against bbox areas.
module tb_raster_tri_scheduler;
    import raster_pkg::*;

    localparam int TO = 16;
    localparam logic [31:0] HANG_TAG = 32'hDEAD_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    raster_tri_scheduler_if #(.ID_W(8)) ifc ();

    raster_tri_scheduler #(
        .FIFO_DEPTH (4),
        .ID_W       (8),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        int          xmin;
        int          xmax;
        int          ymin;
        int          ymax;
        bit          same;
        logic [31:0] exp_cnt;
        int          exp_starts;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   push_cyc = 0;
    exp_t exp_q[$];
    logic [7:0] id_model = 8'd0;

    int          start_cnt = 0;
    int          rpt_cnt = 0;
    int          last_start_cyc = 0;
    int          last_rpt_cyc = 0;
    logic [7:0]  last_rpt_id = 8'd0;

    bit ready_en = 1'b0;
    bit ready_rand = 1'b0;
    bit pop_always = 1'b1;
    bit done_same = 1'b0;
    bit stray = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    function automatic int bbox(input tri_setup_t t);
        return (int'(t.xmax) - int'(t.xmin) + 1) * (int'(t.ymax) - int'(t.ymin) + 1);
    endfunction

    function automatic tri_setup_t mk(input int xmin, input int xmax, input int ymin, input int ymax,
                                      input logic [31:0] tag);
        tri_setup_t t;
        t = '0;
        t.xmin = xmin;  t.xmax = xmax;  t.ymin = ymin;  t.ymax = ymax;
        t.l0_dx = $urandom(); t.l0_dy = $urandom(); t.l1_dx = $urandom(); t.l1_dy = $urandom();
        t.l2_dx = $urandom(); t.l2_dy = $urandom(); t.w0_00 = $urandom(); t.w1_00 = $urandom();
        t.w2_00 = $urandom(); t.v0_raster_z = $urandom(); t.v1_raster_z = $urandom();
        t.v2_raster_z = $urandom();
        t.recip_area = tag;
        return t;
    endfunction

    // Fragment generator + shader consumer model, and report scoreboard.
    initial begin : env
        bit active, hang, missed, fv, pp;
        bit s_start, s_fire, s_done;
        int left;
        tri_setup_t s_setup;
        exp_t e;
        active = 0; hang = 0; missed = 0; left = 0;
        ifc.fg_ready = 0; ifc.fg_done = 0; ifc.fg_frag_val = 0; ifc.fg_pop_frag = 0;
        forever begin
            @(negedge clk);
            s_start = ifc.fg_start;
            s_fire  = ifc.fg_frag_val && ifc.fg_pop_frag;
            s_done  = ifc.fg_done;
            s_setup = ifc.fg_setup;
            if (rst) begin
                if (s_start) begin
                    start_cnt++;
                    last_start_cyc = cyc;
                end
                if (ifc.rpt_valid) begin
                    rpt_cnt++;
                    last_rpt_cyc = cyc;
                    last_rpt_id  = ifc.rpt_id;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rpt_unexpected: got report id %0d cnt %0d, required none",
                                 ifc.rpt_id, ifc.rpt_frag_cnt);
                    end else begin
                        e = exp_q.pop_front();
                        check("rpt_id", 64'(ifc.rpt_id), 64'(e.id));
                        check("rpt_frag_cnt", 64'(ifc.rpt_frag_cnt), 64'(e.cnt));
                    end
                end
            end
            @(posedge clk);
            cyc++;
            #1;
            if (!rst) begin
                active = 0;
                missed = 0;
            end else begin
                if (s_start) begin
                    active = 1;
                    left   = bbox(s_setup);
                    hang   = (s_setup.recip_area == HANG_TAG);
                end else if (active && s_fire) begin
                    left--;
                end
                if (s_done) active = 0;
            end
            ifc.fg_ready = ready_en && (!ready_rand || ($urandom_range(0, 3) != 0));
            if (stray) begin
                ifc.fg_frag_val = 1; ifc.fg_pop_frag = 1; ifc.fg_done = 1;
            end else begin
                fv = active && (left > 0);
                pp = pop_always || missed || ($urandom_range(0, 1) == 1);
                ifc.fg_frag_val = fv;
                ifc.fg_pop_frag = pp;
                ifc.fg_done = active && !hang && ((left == 0) || (done_same && left == 1 && fv && pp));
                missed = fv && !pp;
            end
        end
    end

    task automatic push(input tri_setup_t t, input logic [31:0] exp_cnt);
        int  w = 0;
        bit  ok = 1;
        ifc.tri_in = t;
        ifc.tri_valid = 1;
        forever begin
            @(negedge clk);
            if (ifc.tri_ready) break;
            w++;
            if (w > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL push_wait: tri_ready stayed 0 for %0d cycles, required 1", w);
                ok = 0;
                break;
            end
        end
        if (ok) begin
            push_cyc = cyc;
            exp_q.push_back('{id_model, exp_cnt});
            id_model++;
        end
        @(posedge clk);
        #1;
        ifc.tri_valid = 0;
    endtask

    task automatic wait_idle();
        int w = 0;
        forever begin
            @(negedge clk);
            if (!ifc.busy && exp_q.size() == 0) break;
            w++;
            if (w > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL idle_wait: busy=%0b pending=%0d, required idle", ifc.busy, exp_q.size());
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input int s0);
        int w = 0;
        while (start_cnt == s0) begin
            @(posedge clk);
            #2;
            w++;
            if (w > 100) begin
                n_checks++;
                n_fail++;
                $display("FAIL start_wait: fg_start count %0d, required > %0d", start_cnt, s0);
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 0;
        exp_q.delete();
        id_model = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #2;
    endtask

    vec_t vecs[8];

    initial begin : main
        int s0, r0, rc, w;
        int wdt, hdt, xm, ym;
        bit dg;
        ifc.tri_valid = 0;
        ifc.tri_in = '0;

        vecs[0] = '{0, 3, 0, 1, 1'b0, 32'd8, 1};
        vecs[1] = '{5, 2, 0, 1, 1'b0, 32'd0, 0};
        vecs[2] = '{0, 0, 4, 1, 1'b0, 32'd0, 0};
        vecs[3] = '{0, 3, 0, 0, 1'b1, 32'd4, 1};
        vecs[4] = '{-2, 1, -1, 0, 1'b0, 32'd8, 1};
        vecs[5] = '{7, 7, 7, 7, 1'b0, 32'd1, 1};
        vecs[6] = '{-3, -5, 0, 0, 1'b0, 32'd0, 0};
        vecs[7] = '{-1, 1, 0, 0, 1'b1, 32'd3, 1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_tri_ready", 64'(ifc.tri_ready), 64'd1);
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_fg_start", 64'(ifc.fg_start), 64'd0);
        check("rst_rpt_valid", 64'(ifc.rpt_valid), 64'd0);
        check("rst_err_timeout", 64'(ifc.err_timeout), 64'd0);
        check("rst_fg_setup_xmax", 64'(ifc.fg_setup.xmax), 64'd0);
        check("rst_rpt_id", 64'(ifc.rpt_id), 64'd0);
        check("rst_rpt_frag_cnt", 64'(ifc.rpt_frag_cnt), 64'd0);
        @(posedge clk);
        #2;

        // Directed table: one triangle at a time, generator always ready, consumer always pops
        ready_en = 1;
        pop_always = 1;
        for (int i = 0; i < 8; i++) begin
            done_same = vecs[i].same;
            s0 = start_cnt;
            r0 = rpt_cnt;
            push(mk(vecs[i].xmin, vecs[i].xmax, vecs[i].ymin, vecs[i].ymax, 32'd0), vecs[i].exp_cnt);
            wait_idle();
            check("vec_starts", 64'(start_cnt - s0), 64'(vecs[i].exp_starts));
            check("vec_reports", 64'(rpt_cnt - r0), 64'd1);
            if (vecs[i].exp_starts != 0) check("vec_start_latency", 64'(last_start_cyc - push_cyc), 64'd3);
            else check("vec_degen_rpt_latency", 64'(last_rpt_cyc - push_cyc), 64'd3);
        end
        done_same = 0;

        // fg_done and pops while idle are ignored
        r0 = rpt_cnt;
        stray = 1;
        repeat (3) @(posedge clk);
        stray = 0;
        @(posedge clk);
        #2;
        check("idle_done_reports", 64'(rpt_cnt - r0), 64'd0);
        check("idle_done_busy", 64'(ifc.busy), 64'd0);
        push(mk(0, 1, 0, 1, 32'd0), 32'd4);
        wait_idle();

        // Backpressure: generator stalled, FIFO fills after 4 stored + 1 in flight
        do_reset();
        ready_en = 0;
        s0 = start_cnt;
        r0 = rpt_cnt;
        for (int i = 0; i < 5; i++) push(mk(0, 0, 0, 0, 32'd0), 32'd1);
        @(negedge clk);
        check("bp_tri_ready", 64'(ifc.tri_ready), 64'd0);
        check("bp_no_start", 64'(start_cnt - s0), 64'd0);
        check("bp_busy", 64'(ifc.busy), 64'd1);
        ready_en = 1;
        push(mk(0, 0, 0, 0, 32'd0), 32'd1);
        wait_idle();
        check("bp_starts", 64'(start_cnt - s0), 64'd6);
        check("bp_reports", 64'(rpt_cnt - r0), 64'd6);

        // Watchdog: hung generator times out after TO RUN cycles, next triangle proceeds
        do_reset();
        s0 = start_cnt;
        r0 = rpt_cnt;
        push(mk(0, 1, 0, 0, HANG_TAG), 32'd2);
        push(mk(0, 0, 0, 0, 32'd0), 32'd1);
        wait_start(s0);
        check("to_err_before", 64'(ifc.err_timeout), 64'd0);
        rc = 0;
        w = 0;
        while (rpt_cnt == r0 && w < 60) begin
            @(posedge clk);
            #2;
            w++;
        end
        check("to_report_seen", 64'(rpt_cnt - r0), 64'd1);
        check("to_latency", 64'(last_rpt_cyc - last_start_cyc), 64'(TO + 1));
        check("to_err_set", 64'(ifc.err_timeout), 64'd1);
        wait_idle();
        check("to_next_launched", 64'(start_cnt - s0), 64'd2);
        check("to_err_sticky", 64'(ifc.err_timeout), 64'd1);

        // Mid-RUN reset: outputs return to reset values at once, no report for the in-flight triangle
        s0 = start_cnt;
        r0 = rpt_cnt;
        push(mk(0, 3, 0, 3, HANG_TAG), 32'd16);
        wait_start(s0);
        #1;
        rst = 0;
        #1;
        check("mid_rst_busy", 64'(ifc.busy), 64'd0);
        check("mid_rst_fg_start", 64'(ifc.fg_start), 64'd0);
        check("mid_rst_rpt_valid", 64'(ifc.rpt_valid), 64'd0);
        check("mid_rst_err", 64'(ifc.err_timeout), 64'd0);
        check("mid_rst_fg_setup", 64'(ifc.fg_setup.xmax), 64'd0);
        check("mid_rst_tri_ready", 64'(ifc.tri_ready), 64'd1);
        exp_q.delete();
        id_model = 8'd0;
        @(negedge clk);
        rst = 1;
        repeat (30) @(posedge clk);
        #2;
        check("mid_rst_no_report", 64'(rpt_cnt - r0), 64'd0);

        // Id wrap: 257 degenerate triangles, the last report carries id 0
        r0 = rpt_cnt;
        for (int i = 0; i < 257; i++) push(mk(1, 0, 0, 0, 32'd0), 32'd0);
        wait_idle();
        check("wrap_reports", 64'(rpt_cnt - r0), 64'd257);
        check("wrap_last_id", 64'(last_rpt_id), 64'd0);

        // Random traffic: ragged generator readiness, random consumer pops, mixed degenerate shapes
        do_reset();
        ready_rand = 1;
        pop_always = 0;
        r0 = rpt_cnt;
        for (int i = 0; i < 60; i++) begin
            done_same = ($urandom_range(0, 1) == 1);
            dg  = ($urandom_range(0, 4) == 0);
            xm  = int'($urandom_range(0, 15)) - 8;
            ym  = int'($urandom_range(0, 15)) - 8;
            wdt = int'($urandom_range(1, 2));
            hdt = int'($urandom_range(1, 2));
            if (dg) push(mk(xm, xm - 1 - int'($urandom_range(0, 3)), ym, ym + hdt - 1, 32'd0), 32'd0);
            else push(mk(xm, xm + wdt - 1, ym, ym + hdt - 1, 32'd0), 32'(wdt * hdt));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_idle();
        check("rand_reports", 64'(rpt_cnt - r0), 64'd60);
        check("rand_no_timeout", 64'(ifc.err_timeout), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "global timeout");
    end

endmodule
